alu_execute: RTL and testbench

- Execute stage directly downstream of the ALU operand-select logic.
- Accepts an operand/opcode bundle (alu_a, alu_b, alu_ic, alu_opcode, store_carry, store_overflow) under a valid/ready handshake.
- Computes the result and holds it in a one-entry output register.
- Owns the architectural carry and overflow flag registers; the carry flag feeds back to operand select for CARRY/BORROW instructions.

---
 rtl/alu_execute_pkg.sv | 17 +
 rtl/alu_shifter.sv | 42 ++++
 rtl/alu_execute.sv | 91 +++++++++
 tb/tb_alu_execute.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_execute_pkg.sv
// Shared constants for the ALU execute stage: opcode encodings and widths.
package alu_execute_pkg;

  localparam int unsigned OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_XOR = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_LSL = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_LSR = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_ASR = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_CSL = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_CSR = 4'h9;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit: logical, arithmetic and circular shifts of one word.
module alu_shifter
  import alu_execute_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic [WORD_WIDTH-1:0] value,
  input  logic [WORD_WIDTH-1:0] amount,
  input  logic [OPCODE_W-1:0]   opcode,
  output logic [WORD_WIDTH-1:0] shifted
);

  localparam int unsigned SHW = $clog2(WORD_WIDTH);
  localparam logic [SHW:0] WIDTH_CNT = (SHW+1)'(WORD_WIDTH);

  logic [SHW-1:0]        amt;
  logic                  over;
  logic [SHW:0]          comp;
  logic [WORD_WIDTH-1:0] rotl;
  logic [WORD_WIDTH-1:0] rotr;

  // Rotates use only the low bits, so a negative amount rotates the other way.
  assign amt  = amount[SHW-1:0];
  assign over = |amount[WORD_WIDTH-1:SHW];
  assign comp = WIDTH_CNT - {1'b0, amt};
  assign rotl = (value << amt) | (value >> comp);
  assign rotr = (value >> amt) | (value << comp);

  always_comb begin
    shifted = '0;
    case (opcode)
      OP_LSL:  shifted = over ? '0 : (value << amt);
      OP_LSR:  shifted = over ? '0 : (value >> amt);
      OP_ASR:  shifted = over ? {WORD_WIDTH{value[WORD_WIDTH-1]}}
                              : $unsigned($signed(value) >>> amt);
      OP_CSL:  shifted = rotl;
      OP_CSR:  shifted = rotr;
      default: shifted = '0;
    endcase
  end

endmodule

// File: rtl/alu_execute.sv
// ALU execute stage: computes the result into a one-entry output register
// under valid/ready and owns the architectural carry and overflow flags.
module alu_execute
  import alu_execute_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] alu_a,
  input  logic [WORD_WIDTH-1:0] alu_b,
  input  logic                  alu_ic,
  input  logic [OPCODE_W-1:0]   alu_opcode,
  input  logic                  store_carry,
  input  logic                  store_overflow,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  overflow
);

  logic [WORD_WIDTH:0]   sum;
  logic [WORD_WIDTH-1:0] shifted;
  logic [WORD_WIDTH-1:0] res_c;
  logic                  cout_c;
  logic                  ovf_c;
  logic                  accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  assign sum = {1'b0, alu_a} + {1'b0, alu_b} + {{WORD_WIDTH{1'b0}}, alu_ic};

  alu_shifter #(.WORD_WIDTH(WORD_WIDTH)) u_shifter (
    .value   (alu_a),
    .amount  (alu_b),
    .opcode  (alu_opcode),
    .shifted (shifted)
  );

  // Result mux; carry-out and overflow are only meaningful for ADD, otherwise 0.
  always_comb begin
    res_c  = '0;
    cout_c = 1'b0;
    ovf_c  = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        res_c  = sum[WORD_WIDTH-1:0];
        cout_c = sum[WORD_WIDTH];
        ovf_c  = (alu_a[WORD_WIDTH-1] == alu_b[WORD_WIDTH-1]) &&
                 (sum[WORD_WIDTH-1] != alu_a[WORD_WIDTH-1]);
      end
      OP_AND:  res_c = alu_a & alu_b;
      OP_OR:   res_c = alu_a | alu_b;
      OP_XOR:  res_c = alu_a ^ alu_b;
      OP_LSL, OP_LSR, OP_ASR, OP_CSL, OP_CSR: res_c = shifted;
      default: res_c = '0;
    endcase
  end

  // Flush outranks both accept and consume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= res_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Flags commit when the op is accepted, not when its result is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept && store_carry)    carry    <= cout_c;
      if (accept && store_overflow) overflow <= ovf_c;
    end
  end

endmodule

// File: tb/tb_alu_execute.sv
// Directed self-checking bench for alu_execute with hand-computed expectations.
module tb_alu_execute;
  import alu_execute_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_ic;
  logic [3:0]  alu_opcode;
  logic        store_carry;
  logic        store_overflow;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  alu_execute #(.WORD_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_ic         (alu_ic),
    .alu_opcode     (alu_opcode),
    .store_carry    (store_carry),
    .store_overflow (store_overflow),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .carry          (carry),
    .overflow       (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ic, input logic sc, input logic so);
    in_valid       = 1'b1;
    alu_opcode     = op;
    alu_a          = a;
    alu_b          = b;
    alu_ic         = ic;
    store_carry    = sc;
    store_overflow = so;
  endtask

  task automatic idle();
    in_valid       = 1'b0;
    alu_opcode     = OP_NOP;
    alu_a          = '0;
    alu_b          = '0;
    alu_ic         = 1'b0;
    store_carry    = 1'b0;
    store_overflow = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result actual=%h expected=%h", result, 32'h0); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%b expected=0", out_valid); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry actual=%b expected=0", carry); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow actual=%b expected=0", overflow); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b expected=1", in_ready); end
  endtask

  task automatic test_add_overflow();
    drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    idle();
    checks++; if (result !== 32'h8000_0000) begin failures++; $display("FAIL add_ovf_result actual=%h expected=%h", result, 32'h8000_0000); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_ovf_out_valid actual=%b expected=1", out_valid); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL add_ovf_carry actual=%b expected=0", carry); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL add_ovf_overflow actual=%b expected=1", overflow); end
  endtask

  task automatic test_back_to_back_carry();
    drive(OP_ADD, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL chain_first_result actual=%h expected=%h", result, 32'h0); end
    checks++; if (carry !== 1'b1) begin failures++; $display("FAIL chain_carry_set actual=%b expected=1", carry); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL chain_overflow_kept actual=%b expected=1", overflow); end
    drive(OP_ADD, 32'h0, 32'h5, carry, 1'b0, 1'b0);
    @(posedge clk); #1;
    idle();
    checks++; if (result !== 32'h6) begin failures++; $display("FAIL chain_second_result actual=%h expected=%h", result, 32'h6); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL chain_out_valid actual=%b expected=1", out_valid); end
    checks++; if (carry !== 1'b1) begin failures++; $display("FAIL chain_carry_held actual=%b expected=1", carry); end
  endtask

  task automatic test_shifts();
    logic [3:0]  ops [8];
    logic [31:0] amts [8];
    logic [31:0] exps [8];
    ops[0] = OP_LSL;  amts[0] = 32'd4;         exps[0] = 32'h0000_0010;
    ops[1] = OP_ASR;  amts[1] = 32'd40;        exps[1] = 32'hFFFF_FFFF;
    ops[2] = OP_CSR;  amts[2] = 32'd1;         exps[2] = 32'hC000_0000;
    ops[3] = OP_CSL;  amts[3] = 32'hFFFF_FFFF; exps[3] = 32'hC000_0000;
    ops[4] = OP_LSR;  amts[4] = 32'd32;        exps[4] = 32'h0000_0000;
    ops[5] = OP_ASR;  amts[5] = 32'd4;         exps[5] = 32'hF800_0000;
    ops[6] = OP_NOP;  amts[6] = 32'd3;         exps[6] = 32'h0000_0000;
    ops[7] = 4'hF;    amts[7] = 32'd3;         exps[7] = 32'h0000_0000;
    for (int i = 0; i < 8; i++) begin
      drive(ops[i], 32'h8000_0001, amts[i], 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (result !== exps[i] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL shift_%0d actual=%h/%b expected=%h/1", i, result, out_valid, exps[i]);
      end
    end
    idle();
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL nonadd_carry_clear actual=%b expected=0", carry); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL nonadd_overflow_clear actual=%b expected=0", overflow); end
  endtask

  task automatic test_backpressure();
    drive(OP_ADD, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if (result !== 32'd30) begin failures++; $display("FAIL bp_first_result actual=%h expected=%h", result, 32'd30); end
    out_ready = 1'b0;
    drive(OP_XOR, 32'hF0F0_0000, 32'h0FF0_0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_%0d actual=%b expected=0", i, in_ready); end
      @(posedge clk); #1;
      checks++;
      if (result !== 32'd30 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold_%0d actual=%h/%b expected=%h/1", i, result, out_valid, 32'd30);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready actual=%b expected=1", in_ready); end
    @(posedge clk); #1;
    idle();
    checks++;
    if (result !== 32'hFF00_0000 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_replace actual=%h/%b expected=%h/1", result, out_valid, 32'hFF00_0000);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain actual=%b expected=0", out_valid); end
  endtask

  task automatic test_flush();
    drive(OP_OR, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'h3) begin failures++; $display("FAIL flush_setup actual=%h/%b expected=%h/1", result, out_valid, 32'h3); end
    drive(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid actual=%b expected=0", out_valid); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL flush_carry actual=%b expected=0", carry); end
  endtask

  task automatic test_async_reset();
    drive(OP_ADD, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    idle();
    checks++;
    if (result !== 32'h1 || carry !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_setup actual=%h/%b/%b expected=%h/1/1", result, carry, out_valid, 32'h1);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (result !== 32'h0 || carry !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL areset_clear actual=%h/%b/%b/%b expected=0/0/0/0", result, carry, overflow, out_valid);
    end
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_after actual=%b expected=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back_carry();
    test_shifts();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
